// File: rtl/dm_responder_if.sv
// Request/response bus between the CPU MEM stage (master) and the data-memory
// responder (slave).
interface dm_responder_if;
  logic        req_valid;
  logic        req_ready;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic [1:0]  req_DMWr;
  logic [3:0]  req_DMRd;
  logic        rsp_valid;
  logic [31:0] rsp_rdata;
  logic        rsp_err;
  logic        mem_stall;

  modport master (
    output req_valid, req_addr, req_wdata, req_DMWr, req_DMRd,
    input  req_ready, rsp_valid, rsp_rdata, rsp_err, mem_stall
  );

  modport slave (
    input  req_valid, req_addr, req_wdata, req_DMWr, req_DMRd,
    output req_ready, rsp_valid, rsp_rdata, rsp_err, mem_stall
  );
endinterface

// File: rtl/dm_responder.sv
// Data-memory responder: single outstanding access, fixed WAIT-cycle latency,
// byte-lane stores and sign/zero-extending loads. Macro DM_ALIGN_CHK_EN enables misalignment rejection.
module dm_responder #(
  parameter int DEPTH_WORDS = 1024,
  parameter int WAIT        = 2
) (
  input logic          clk,
  input logic          rst,
  dm_responder_if.slave bus
);

  localparam int AW = $clog2(DEPTH_WORDS);
  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_WAIT = 2'd1;
  localparam logic [1:0] ST_RESP = 2'd2;
  localparam logic [3:0] WAIT_LOAD = 4'(WAIT - 1);

  function automatic logic is_load(input logic [3:0] rd);
    case (rd)
      4'd1, 4'd2, 4'd3, 4'd4, 4'd5: is_load = 1'b1;
      default:                      is_load = 1'b0;
    endcase
  endfunction

  function automatic logic [3:0] byte_en(input logic [1:0] wr, input logic [1:0] lo);
    case (wr)
      2'b01:   byte_en = 4'b1111;
      2'b10:   byte_en = lo[1] ? 4'b1100 : 4'b0011;
      2'b11:   byte_en = 4'b0001 << lo;
      default: byte_en = 4'b0000;
    endcase
  endfunction

  function automatic logic [31:0] lane_data(input logic [1:0] wr, input logic [31:0] wd);
    case (wr)
      2'b10:   lane_data = {2{wd[15:0]}};
      2'b11:   lane_data = {4{wd[7:0]}};
      default: lane_data = wd;
    endcase
  endfunction

  function automatic logic misaligned(input logic [1:0] wr, input logic [3:0] rd,
                                      input logic [1:0] lo);
    logic word_acc;
    logic half_acc;
    word_acc   = (wr == 2'b01) || (rd == 4'd1);
    half_acc   = (wr == 2'b10) || (rd == 4'd2) || (rd == 4'd3);
    misaligned = (word_acc && (lo != 2'b00)) || (half_acc && lo[0]);
  endfunction

  function automatic logic [31:0] load_ext(input logic [3:0] rd, input logic [1:0] lo,
                                           input logic [31:0] word);
    logic [15:0] half;
    logic [7:0]  byt;
    half = lo[1] ? word[31:16] : word[15:0];
    case (lo)
      2'b00:   byt = word[7:0];
      2'b01:   byt = word[15:8];
      2'b10:   byt = word[23:16];
      default: byt = word[31:24];
    endcase
    case (rd)
      4'd1:    load_ext = word;
      4'd2:    load_ext = {{16{half[15]}}, half};
      4'd3:    load_ext = {16'h0000, half};
      4'd4:    load_ext = {{24{byt[7]}}, byt};
      4'd5:    load_ext = {24'h000000, byt};
      default: load_ext = 32'h0000_0000;
    endcase
  endfunction

  logic [1:0]  state_r;
  logic [3:0]  cnt_r;
  logic [31:0] addr_r;
  logic [31:0] wdata_r;
  logic [1:0]  dmwr_r;
  logic [3:0]  dmrd_r;
  logic        rsp_valid_r;
  logic [31:0] rsp_rdata_r;
  logic        rsp_err_r;
  logic [31:0] mem_r [DEPTH_WORDS];

  logic          req_ready_s;
  logic          accept_s;
  logic          go_resp_s;
  logic [31:0]   src_addr_s;
  logic [31:0]   src_wdata_s;
  logic [1:0]    src_wr_s;
  logic [3:0]    src_rd_s;
  logic [AW-1:0] idx_s;
  logic [1:0]    lo_s;
  logic          both_s;
  logic          mis_s;
  logic          err_s;
  logic [3:0]    be_s;
  logic [31:0]   wlane_s;
  logic [31:0]   rdata_s;

  assign req_ready_s = (state_r == ST_IDLE) && !rst;
  assign accept_s    = bus.req_valid && req_ready_s;

  // With WAIT==0 the response is produced on the acceptance edge, so the operand
  // source is the live request in IDLE and the captured copy otherwise.
  always_comb begin
    src_addr_s  = addr_r;
    src_wdata_s = wdata_r;
    src_wr_s    = dmwr_r;
    src_rd_s    = dmrd_r;
    if (state_r == ST_IDLE) begin
      src_addr_s  = bus.req_addr;
      src_wdata_s = bus.req_wdata;
      src_wr_s    = bus.req_DMWr;
      src_rd_s    = bus.req_DMRd;
    end else begin
      src_addr_s  = addr_r;
    end
  end

  // Operation decode, error classification and load data extraction.
  always_comb begin
    idx_s  = src_addr_s[AW+1:2];
    lo_s   = src_addr_s[1:0];
    both_s = (src_wr_s != 2'b00) && is_load(src_rd_s);
`ifdef DM_ALIGN_CHK_EN
    mis_s  = misaligned(src_wr_s, src_rd_s, lo_s);
`else
    mis_s  = 1'b0;
`endif
    err_s   = both_s || mis_s;
    be_s    = mis_s ? 4'b0000 : byte_en(src_wr_s, lo_s);
    wlane_s = lane_data(src_wr_s, src_wdata_s);
    if (err_s) begin
      rdata_s = 32'h0000_0000;
    end else begin
      rdata_s = load_ext(src_rd_s, lo_s, mem_r[idx_s]);
    end
  end

  // Edge that enters RESP: commits the store and registers the response.
  always_comb begin
    go_resp_s = 1'b0;
    case (state_r)
      ST_IDLE: go_resp_s = accept_s && (WAIT == 0);
      ST_WAIT: go_resp_s = (cnt_r == 4'd0);
      default: go_resp_s = 1'b0;
    endcase
  end

  // Control FSM, request capture and registered response outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r     <= ST_IDLE;
      cnt_r       <= 4'd0;
      addr_r      <= 32'h0000_0000;
      wdata_r     <= 32'h0000_0000;
      dmwr_r      <= 2'b00;
      dmrd_r      <= 4'd0;
      rsp_valid_r <= 1'b0;
      rsp_rdata_r <= 32'h0000_0000;
      rsp_err_r   <= 1'b0;
    end else begin
      rsp_valid_r <= go_resp_s;
      rsp_rdata_r <= go_resp_s ? rdata_s : 32'h0000_0000;
      rsp_err_r   <= go_resp_s && err_s;
      case (state_r)
        ST_IDLE: begin
          if (accept_s) begin
            addr_r  <= bus.req_addr;
            wdata_r <= bus.req_wdata;
            dmwr_r  <= bus.req_DMWr;
            dmrd_r  <= bus.req_DMRd;
            if (WAIT == 0) begin
              state_r <= ST_RESP;
            end else begin
              state_r <= ST_WAIT;
              cnt_r   <= WAIT_LOAD;
            end
          end
        end
        ST_WAIT: begin
          if (cnt_r == 4'd0) begin
            state_r <= ST_RESP;
          end else begin
            cnt_r <= cnt_r - 4'd1;
          end
        end
        ST_RESP: state_r <= ST_IDLE;
        default: state_r <= ST_IDLE;
      endcase
    end
  end

  // Storage array is deliberately left out of reset.
  always_ff @(posedge clk) begin
    if (go_resp_s && !rst) begin
      for (int b = 0; b < 4; b++) begin
        if (be_s[b]) begin
          mem_r[idx_s][8*b +: 8] <= wlane_s[8*b +: 8];
        end
      end
    end
  end

  assign bus.req_ready = req_ready_s;
  assign bus.rsp_valid = rsp_valid_r;
  assign bus.rsp_rdata = rsp_rdata_r;
  assign bus.rsp_err   = rsp_err_r;
  assign bus.mem_stall = ((state_r == ST_IDLE) && bus.req_valid) || (state_r == ST_WAIT);

endmodule

// File: tb/tb_dm_responder.sv
// Directed self-checking bench for dm_responder (DEPTH_WORDS=1024, WAIT=2).
module tb_dm_responder;

  logic clk;
  logic rst;
  int   checks;
  int   errors;

  dm_responder_if bus ();

  dm_responder #(.DEPTH_WORDS(1024), .WAIT(2)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Drives one request at a negedge, then waits (bounded) for the response pulse.
  task automatic do_access(input logic [31:0] addr, input logic [31:0] wdata,
                           input logic [1:0] wr, input logic [3:0] rd,
                           output logic [31:0] rdata, output logic err,
                           output int lat, output int stalls);
    @(negedge clk);
    bus.req_valid = 1'b1;
    bus.req_addr  = addr;
    bus.req_wdata = wdata;
    bus.req_DMWr  = wr;
    bus.req_DMRd  = rd;
    #1;
    stalls = bus.mem_stall ? 1 : 0;
    @(posedge clk);
    #1;
    bus.req_valid = 1'b0;
    bus.req_addr  = 32'h0000_0000;
    bus.req_wdata = 32'h0000_0000;
    bus.req_DMWr  = 2'b00;
    bus.req_DMRd  = 4'd0;
    lat   = 0;
    rdata = 32'hDEAD_DEAD;
    err   = 1'bx;
    for (int n = 1; n <= 20; n++) begin
      @(negedge clk);
      if (bus.rsp_valid) begin
        lat   = n;
        rdata = bus.rsp_rdata;
        err   = bus.rsp_err;
        if (bus.mem_stall) stalls = stalls + 100;
        break;
      end else if (bus.mem_stall) begin
        stalls = stalls + 1;
      end
    end
  endtask

  task automatic test_reset;
    rst = 1'b1;
    repeat (2) @(negedge clk);
    checks++;
    if (bus.rsp_valid !== 1'b0 || bus.rsp_err !== 1'b0 || bus.rsp_rdata !== 32'h0000_0000) begin
      errors++;
      $display("FAIL reset_outputs: valid=%b err=%b rdata=%h, want 0/0/00000000",
               bus.rsp_valid, bus.rsp_err, bus.rsp_rdata);
    end
    checks++;
    if (bus.req_ready !== 1'b0 || bus.mem_stall !== 1'b0) begin
      errors++;
      $display("FAIL reset_ready: ready=%b stall=%b, want 0/0", bus.req_ready, bus.mem_stall);
    end
    @(posedge clk);
    #1 rst = 1'b0;
    #1;
    checks++;
    if (bus.req_ready !== 1'b1) begin
      errors++;
      $display("FAIL ready_after_reset: got %b want 1", bus.req_ready);
    end
  endtask

  task automatic test_sw_lw;
    logic [31:0] rd;
    logic        er;
    int          lat;
    int          st;
    do_access(32'h0000_0010, 32'h8899_AABB, 2'b01, 4'd0, rd, er, lat, st);
    checks++;
    if (lat !== 3 || st !== 3 || er !== 1'b0 || rd !== 32'h0000_0000) begin
      errors++;
      $display("FAIL sw_timing: lat=%0d stall=%0d err=%b rdata=%h, want 3/3/0/00000000", lat, st, er, rd);
    end
    do_access(32'h0000_0010, 32'h0000_0000, 2'b00, 4'd1, rd, er, lat, st);
    checks++;
    if (lat !== 3 || st !== 3 || er !== 1'b0 || rd !== 32'h8899_AABB) begin
      errors++;
      $display("FAIL lw_readback: lat=%0d stall=%0d err=%b rdata=%h, want 3/3/0/8899aabb", lat, st, er, rd);
    end
  endtask

  task automatic test_byte;
    logic [31:0] rd;
    logic        er;
    int          lat;
    int          st;
    do_access(32'h0000_0010, 32'h1122_3344, 2'b01, 4'd0, rd, er, lat, st);
    do_access(32'h0000_0013, 32'h0000_00F0, 2'b11, 4'd0, rd, er, lat, st);
    do_access(32'h0000_0013, 32'h0000_0000, 2'b00, 4'd4, rd, er, lat, st);
    checks++;
    if (rd !== 32'hFFFF_FFF0 || er !== 1'b0) begin
      errors++;
      $display("FAIL lb_sign: got %h err=%b want fffffff0 err=0", rd, er);
    end
    do_access(32'h0000_0013, 32'h0000_0000, 2'b00, 4'd5, rd, er, lat, st);
    checks++;
    if (rd !== 32'h0000_00F0) begin
      errors++;
      $display("FAIL lbu_zero: got %h want 000000f0", rd);
    end
    do_access(32'h0000_0010, 32'h0000_0000, 2'b00, 4'd1, rd, er, lat, st);
    checks++;
    if (rd !== 32'hF022_3344) begin
      errors++;
      $display("FAIL sb_merge: got %h want f0223344", rd);
    end
  endtask

  task automatic test_half;
    logic [31:0] rd;
    logic        er;
    int          lat;
    int          st;
    do_access(32'h0000_0012, 32'h0000_8001, 2'b10, 4'd0, rd, er, lat, st);
    do_access(32'h0000_0012, 32'h0000_0000, 2'b00, 4'd2, rd, er, lat, st);
    checks++;
    if (rd !== 32'hFFFF_8001) begin
      errors++;
      $display("FAIL lh_sign: got %h want ffff8001", rd);
    end
    do_access(32'h0000_0012, 32'h0000_0000, 2'b00, 4'd3, rd, er, lat, st);
    checks++;
    if (rd !== 32'h0000_8001) begin
      errors++;
      $display("FAIL lhu_zero: got %h want 00008001", rd);
    end
    do_access(32'h0000_0010, 32'h0000_0000, 2'b00, 4'd2, rd, er, lat, st);
    checks++;
    if (rd !== 32'h0000_3344) begin
      errors++;
      $display("FAIL lh_low: got %h want 00003344", rd);
    end
    do_access(32'h0000_0010, 32'h0000_0000, 2'b00, 4'd1, rd, er, lat, st);
    checks++;
    if (rd !== 32'h8001_3344) begin
      errors++;
      $display("FAIL sh_merge: got %h want 80013344", rd);
    end
  endtask

  task automatic test_wrap;
    logic [31:0] rd;
    logic        er;
    int          lat;
    int          st;
    do_access(32'h0000_1000, 32'h0000_0005, 2'b01, 4'd0, rd, er, lat, st);
    do_access(32'h0000_0000, 32'h0000_0000, 2'b00, 4'd1, rd, er, lat, st);
    checks++;
    if (rd !== 32'h0000_0005) begin
      errors++;
      $display("FAIL wrap: got %h want 00000005", rd);
    end
  endtask

  task automatic test_reset_mid_wait;
    logic [31:0] rd;
    logic        er;
    int          lat;
    int          st;
    int          seen;
    do_access(32'h0000_0020, 32'h0000_0000, 2'b01, 4'd0, rd, er, lat, st);
    @(negedge clk);
    bus.req_valid = 1'b1;
    bus.req_addr  = 32'h0000_0020;
    bus.req_wdata = 32'h0000_0001;
    bus.req_DMWr  = 2'b01;
    bus.req_DMRd  = 4'd0;
    @(posedge clk);
    #1;
    bus.req_valid = 1'b0;
    bus.req_DMWr  = 2'b00;
    checks++;
    if (bus.req_ready !== 1'b0 || bus.mem_stall !== 1'b1) begin
      errors++;
      $display("FAIL wait_flags: ready=%b stall=%b want 0/1", bus.req_ready, bus.mem_stall);
    end
    #2 rst = 1'b1;
    #1;
    checks++;
    if (bus.mem_stall !== 1'b0 || bus.req_ready !== 1'b0) begin
      errors++;
      $display("FAIL async_reset: stall=%b ready=%b want 0/0", bus.mem_stall, bus.req_ready);
    end
    seen = 0;
    repeat (4) begin
      @(negedge clk);
      if (bus.rsp_valid) seen++;
    end
    @(posedge clk);
    #1 rst = 1'b0;
    repeat (3) begin
      @(negedge clk);
      if (bus.rsp_valid) seen++;
    end
    checks++;
    if (seen !== 0) begin
      errors++;
      $display("FAIL no_rsp_after_reset: rsp_valid seen %0d times want 0", seen);
    end
    do_access(32'h0000_0020, 32'h0000_0000, 2'b00, 4'd1, rd, er, lat, st);
    checks++;
    if (rd !== 32'h0000_0000 || lat !== 3) begin
      errors++;
      $display("FAIL store_discarded: rdata=%h lat=%0d want 00000000/3", rd, lat);
    end
  endtask

  task automatic test_both_none;
    logic [31:0] rd;
    logic        er;
    int          lat;
    int          st;
    do_access(32'h0000_0030, 32'hCAFE_F00D, 2'b01, 4'd1, rd, er, lat, st);
    checks++;
    if (rd !== 32'h0000_0000 || er !== 1'b1 || lat !== 3) begin
      errors++;
      $display("FAIL both_err: rdata=%h err=%b lat=%0d want 00000000/1/3", rd, er, lat);
    end
    do_access(32'h0000_0030, 32'h0000_0000, 2'b00, 4'd1, rd, er, lat, st);
    checks++;
    if (rd !== 32'hCAFE_F00D) begin
      errors++;
      $display("FAIL both_store: got %h want cafef00d", rd);
    end
    do_access(32'h0000_0030, 32'h0000_0000, 2'b00, 4'd0, rd, er, lat, st);
    checks++;
    if (rd !== 32'h0000_0000 || er !== 1'b0 || lat !== 3) begin
      errors++;
      $display("FAIL none_op: rdata=%h err=%b lat=%0d want 00000000/0/3", rd, er, lat);
    end
    do_access(32'h0000_0030, 32'h0000_0000, 2'b00, 4'd6, rd, er, lat, st);
    checks++;
    if (rd !== 32'h0000_0000 || er !== 1'b0) begin
      errors++;
      $display("FAIL bad_load_code: rdata=%h err=%b want 00000000/0", rd, er);
    end
  endtask

  task automatic test_align;
    logic [31:0] rd;
    logic        er;
    int          lat;
    int          st;
    logic [31:0] exp_word;
    logic        exp_err;
`ifdef DM_ALIGN_CHK_EN
    exp_word = 32'h0000_0000;
    exp_err  = 1'b1;
`else
    exp_word = 32'hDEAD_BEEF;
    exp_err  = 1'b0;
`endif
    do_access(32'h0000_0022, 32'hDEAD_BEEF, 2'b01, 4'd0, rd, er, lat, st);
    checks++;
    if (er !== exp_err || lat !== 3) begin
      errors++;
      $display("FAIL misalign_err: err=%b lat=%0d want %b/3", er, lat, exp_err);
    end
    do_access(32'h0000_0020, 32'h0000_0000, 2'b00, 4'd1, rd, er, lat, st);
    checks++;
    if (rd !== exp_word) begin
      errors++;
      $display("FAIL misalign_word: got %h want %h", rd, exp_word);
    end
  endtask

  initial begin
    checks        = 0;
    errors        = 0;
    rst           = 1'b1;
    bus.req_valid = 1'b0;
    bus.req_addr  = 32'h0000_0000;
    bus.req_wdata = 32'h0000_0000;
    bus.req_DMWr  = 2'b00;
    bus.req_DMRd  = 4'd0;
    test_reset();
    test_sw_lw();
    test_byte();
    test_half();
    test_wrap();
    test_reset_mid_wait();
    test_both_none();
    test_align();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
